// File: rtl/fpu_round_pack.sv
// Rounds an unpacked double-precision operand (sign, 13-bit biased exponent,
// 57-bit significand with guard/round/sticky) and packs it into IEEE 754.
//
// Handshake: an operand moves in on a rising edge where i_valid && o_ready.
// A result moves out on a rising edge where o_valid && i_ready. o_ready is
// high only in IDLE and o_valid only in OUT, so the two never overlap. The
// result is first sampled valid at edge t+3+k after acceptance at edge t
// (k = left-normalise steps), or at t+2 for NaN, infinity and zero.
module fpu_round_pack #(
  parameter int p_max_rshift = 57
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_sign,
  input  logic [12:0]  i_exp,
  input  logic [56:0]  i_sig,
  input  logic         i_nan,
  input  logic         i_inf,
  input  logic [1:0]   rounding_mode,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [0:63]  o_result,
  output logic [2:0]   o_flags,
  output logic [1:0]   o_dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NORM  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  logic [1:0]         r_state;
  logic               r_sign;
  logic signed [13:0] r_exp;
  logic [56:0]        r_sig;
  logic               r_nan;
  logic               r_inf;
  logic [1:0]         r_mode;
  logic [63:0]        r_result;
  logic [2:0]         r_flags;

  // Denormalisation right shift: one extra exponent bit keeps 1 - exp
  // representable for the most negative input exponent.
  logic signed [13:0] w_neg_amt;
  logic [13:0]        w_rs_amt;
  logic [56:0]        w_rs_mask;
  logic [56:0]        w_rs_sig;

  always_comb begin
    w_neg_amt = 14'sd1 - r_exp;
    w_rs_amt  = $unsigned(w_neg_amt);
    if ($unsigned(w_neg_amt) > 14'(p_max_rshift)) begin
      w_rs_amt = 14'(p_max_rshift);
    end
    w_rs_mask = (57'd1 << w_rs_amt) - 57'd1;
    w_rs_sig  = (r_sig >> w_rs_amt);
    w_rs_sig[0] = w_rs_sig[0] | (|(r_sig & w_rs_mask));
  end

  // Rounding datapath, evaluated from the normalised registers in ROUND.
  logic               w_inexact;
  logic               w_inc;
  logic [53:0]        w_sum;
  logic               w_carry;
  logic [52:0]        w_mant;
  logic signed [13:0] w_rexp;
  logic               w_ovf;
  logic               w_denorm;
  logic               w_to_inf;
  logic [10:0]        w_efield;
  logic [63:0]        w_round_result;
  logic [2:0]         w_round_flags;

  always_comb begin
    w_inexact = |r_sig[2:0];
    w_inc     = 1'b0;
    case (r_mode)
      RM_RNE:  w_inc = r_sig[2] & (r_sig[1] | r_sig[0] | r_sig[3]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RUP:  w_inc = w_inexact & ~r_sign;
      RM_RDN:  w_inc = w_inexact & r_sign;
      default: w_inc = 1'b0;
    endcase

    w_sum    = {1'b0, r_sig[55:3]} + {53'd0, w_inc};
    w_carry  = w_sum[53];
    w_mant   = w_carry ? w_sum[53:1] : w_sum[52:0];
    w_rexp   = r_exp + (w_carry ? 14'sd1 : 14'sd0);
    w_ovf    = (w_rexp >= 14'sd2047);
    w_denorm = ~w_mant[52];
    w_efield = w_denorm ? 11'd0 : w_rexp[10:0];

    w_to_inf = (r_mode == RM_RNE) ||
               ((r_mode == RM_RUP) && !r_sign) ||
               ((r_mode == RM_RDN) && r_sign);

    if (w_ovf) begin
      w_round_result = w_to_inf ? {r_sign, 11'h7FF, 52'd0}
                                : {r_sign, 11'h7FE, {52{1'b1}}};
      w_round_flags  = 3'b101;
    end else begin
      w_round_result = {r_sign, w_efield, w_mant[51:0]};
      w_round_flags  = {1'b0, w_denorm & w_inexact, w_inexact};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= S_IDLE;
      r_sign   <= 1'b0;
      r_exp    <= 14'sd0;
      r_sig    <= 57'd0;
      r_nan    <= 1'b0;
      r_inf    <= 1'b0;
      r_mode   <= RM_RNE;
      r_result <= 64'd0;
      r_flags  <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_sign  <= i_sign;
            r_exp   <= {i_exp[12], i_exp};
            r_sig   <= i_sig;
            r_nan   <= i_nan;
            r_inf   <= i_inf;
            r_mode  <= rounding_mode;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_nan) begin
            r_result <= 64'h7FF8_0000_0000_0000;
            r_flags  <= 3'b000;
            r_state  <= S_OUT;
          end else if (r_inf) begin
            r_result <= {r_sign, 11'h7FF, 52'd0};
            r_flags  <= 3'b000;
            r_state  <= S_OUT;
          end else if (r_sig == 57'd0) begin
            r_result <= {r_sign, 63'd0};
            r_flags  <= 3'b000;
            r_state  <= S_OUT;
          end else if (r_exp < 14'sd1) begin
            // After the shift exp is 1, which is already a ROUND condition.
            r_sig   <= w_rs_sig;
            r_exp   <= 14'sd1;
            r_state <= S_ROUND;
          end else if (r_sig[56]) begin
            r_sig   <= {1'b0, r_sig[56:2], r_sig[1] | r_sig[0]};
            r_exp   <= r_exp + 14'sd1;
            r_state <= S_ROUND;
          end else if (r_sig[55] || (r_exp == 14'sd1)) begin
            r_state <= S_ROUND;
          end else begin
            r_sig <= {r_sig[55:0], 1'b0};
            r_exp <= r_exp - 14'sd1;
          end
        end
        S_ROUND: begin
          r_result <= w_round_result;
          r_flags  <= w_round_flags;
          r_state  <= S_OUT;
        end
        S_OUT: begin
          if (i_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready     = (r_state == S_IDLE);
  assign o_valid     = (r_state == S_OUT);
  assign o_result    = r_result;
  assign o_flags     = r_flags;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fpu_round_pack.sv
// Bench for fpu_round_pack: directed corner cases plus randomized operands
// checked against an exact-arithmetic rounding model.
module tb_fpu_round_pack;

  logic         i_clk;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic         i_sign;
  logic [12:0]  i_exp;
  logic [56:0]  i_sig;
  logic         i_nan;
  logic         i_inf;
  logic [1:0]   rounding_mode;
  logic         o_valid;
  logic         i_ready;
  logic [0:63]  o_result;
  logic [2:0]   o_flags;
  logic [1:0]   o_dbg_state;

  int n_checks;
  int n_errs;

  logic [66:0] exp_q[$];
  int          lat_q[$];

  fpu_round_pack #(.p_max_rshift(57)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_sig(i_sig), .i_nan(i_nan),
    .i_inf(i_inf), .rounding_mode(rounding_mode), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_flags(o_flags),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Exact model: value = sig * 2^(e-1078); pick the quantum of the target
  // format (normal or subnormal), divide, and round the remainder.
  function automatic logic [66:0] ref_model(input logic sign, input int e,
      input logic [56:0] sig, input logic nan, input logic inf,
      input logic [1:0] mode, output int lat);
    logic [127:0] wide, mant, rem, half;
    int msb, be, s, k;
    logic inexact, inc, ovf, to_inf;
    logic [63:0] res;
    logic [2:0]  flg;
    lat = 2;
    if (nan) return {64'h7FF8_0000_0000_0000, 3'b000};
    if (inf) return {sign, 11'h7FF, 52'd0, 3'b000};
    if (sig == 57'd0) return {sign, 63'd0, 3'b000};
    msb = 0;
    for (int i = 0; i < 57; i++) if (sig[i]) msb = i;
    k = 0;
    if (msb < 55 && e > 1) k = ((55 - msb) < (e - 1)) ? (55 - msb) : (e - 1);
    lat = 3 + k;
    be = msb + e - 55;
    if (be < 1) be = 1;
    s = be - e + 3;
    wide = 128'(sig);
    if (s <= 0) begin
      mant = wide << (-s);
      rem  = 128'd0;
      half = 128'd1;
    end else if (s > 100) begin
      mant = 128'd0;
      rem  = wide;
      half = {1'b1, 127'd0};
    end else begin
      mant = wide >> s;
      rem  = wide - (mant << s);
      half = 128'd1 << (s - 1);
    end
    inexact = (rem != 128'd0);
    case (mode)
      2'b00:   inc = (rem > half) || ((rem == half) && mant[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = inexact && !sign;
      default: inc = inexact && sign;
    endcase
    mant = mant + 128'(inc);
    if (mant == (128'd1 << 53)) begin
      mant = 128'd1 << 52;
      be++;
    end
    ovf = mant[52] && (be >= 2047);
    to_inf = (mode == 2'b00) || (mode == 2'b10 && !sign) || (mode == 2'b11 && sign);
    if (ovf) begin
      res = to_inf ? {sign, 11'h7FF, 52'd0} : {sign, 11'h7FE, {52{1'b1}}};
      flg = 3'b101;
    end else begin
      res = {sign, (mant[52] ? be[10:0] : 11'd0), mant[51:0]};
      flg = {1'b0, !mant[52] && inexact, inexact};
    end
    return {res, flg};
  endfunction

  // driver tasks
  task automatic send(input logic sg, input logic [12:0] ex, input logic [56:0] sv,
                      input logic nan, input logic inf, input logic [1:0] md);
    int lat;
    @(negedge i_clk);
    chk("ready_idle", 64'(o_ready), 64'd1);
    i_sign = sg; i_exp = ex; i_sig = sv; i_nan = nan; i_inf = inf;
    rounding_mode = md; i_valid = 1'b1;
    exp_q.push_back(ref_model(sg, int'($signed(ex)), sv, nan, inf, md, lat));
    lat_q.push_back(lat);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    // scramble inputs so anything not latched at acceptance shows up
    i_sign = 1'($urandom()); i_exp = 13'($urandom()); i_sig = 57'({$urandom(), $urandom()});
    i_nan = 1'($urandom()); i_inf = 1'($urandom()); rounding_mode = 2'($urandom());
  endtask

  task automatic collect(input int hold, output logic [63:0] got_res, output logic [2:0] got_flg);
    int cyc;
    logic [66:0] e;
    int el;
    cyc = 0;
    while (!o_valid && cyc < 200) begin
      @(posedge i_clk);
      #1;
      cyc++;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    got_res = o_result;
    got_flg = o_flags;
    chk("valid", 64'(o_valid), 64'd1);
    chk("latency", 64'(cyc + 1), 64'(el));
    chk("result", o_result, e[66:3]);
    chk("flags", 64'(o_flags), 64'(e[2:0]));
    for (int h = 0; h < hold; h++) begin
      @(posedge i_clk);
      #1;
      chk("hold_valid", 64'(o_valid), 64'd1);
      chk("hold_result", o_result, e[66:3]);
      chk("hold_flags", 64'(o_flags), 64'(e[2:0]));
      chk("hold_ready", 64'(o_ready), 64'd0);
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    chk("release_valid", 64'(o_valid), 64'd0);
    chk("release_ready", 64'(o_ready), 64'd1);
  endtask

  task automatic directed(input string tag, input logic sg, input logic [12:0] ex,
                          input logic [56:0] sv, input logic nan, input logic inf,
                          input logic [1:0] md, input logic [63:0] want_res,
                          input logic [2:0] want_flg, input int hold);
    logic [63:0] r;
    logic [2:0]  f;
    send(sg, ex, sv, nan, inf, md);
    collect(hold, r, f);
    chk({tag, "_res"}, r, want_res);
    chk({tag, "_flg"}, 64'(f), 64'(want_flg));
  endtask

  initial begin
    logic [56:0] sg;
    logic [12:0] ex;
    logic [63:0] r;
    logic [2:0]  f;
    int m, cat, ev, hold;
    logic seen;

    n_checks = 0; n_errs = 0;
    i_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_sign = 1'b0;
    i_exp = 13'd0; i_sig = 57'd0; i_nan = 1'b0; i_inf = 1'b0; rounding_mode = 2'b00;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_result", o_result, 64'd0);
    chk("rst_flags", 64'(o_flags), 64'd0);
    chk("rst_state", 64'(o_dbg_state), 64'd0);  // IDLE encodes as 0
    @(negedge i_clk);
    i_rst = 1'b1;

    directed("one", 1'b0, 13'd1023, 57'd1 << 55, 1'b0, 1'b0, 2'b00, 64'h3FF0_0000_0000_0000, 3'b000, 0);
    directed("three", 1'b0, 13'd1023, 57'd3 << 55, 1'b0, 1'b0, 2'b00, 64'h4008_0000_0000_0000, 3'b000, 1);
    directed("lshift", 1'b0, 13'd1033, 57'd1 << 45, 1'b0, 1'b0, 2'b00, 64'h3FF0_0000_0000_0000, 3'b000, 0);
    directed("g_rne", 1'b0, 13'd1023, (57'd1 << 55) | 57'd4, 1'b0, 1'b0, 2'b00, 64'h3FF0_0000_0000_0000, 3'b001, 0);
    directed("g_rtz", 1'b0, 13'd1023, (57'd1 << 55) | 57'd4, 1'b0, 1'b0, 2'b01, 64'h3FF0_0000_0000_0000, 3'b001, 0);
    directed("g_rup", 1'b0, 13'd1023, (57'd1 << 55) | 57'd4, 1'b0, 1'b0, 2'b10, 64'h3FF0_0000_0000_0001, 3'b001, 0);
    directed("ovf_rne", 1'b0, 13'd2047, 57'd1 << 55, 1'b0, 1'b0, 2'b00, 64'h7FF0_0000_0000_0000, 3'b101, 0);
    directed("ovf_rtz", 1'b0, 13'd2047, 57'd1 << 55, 1'b0, 1'b0, 2'b01, 64'h7FEF_FFFF_FFFF_FFFF, 3'b101, 0);
    directed("uflow", 1'b1, 13'h1F9C, 57'd1 << 55, 1'b0, 1'b0, 2'b00, 64'h8000_0000_0000_0000, 3'b011, 0);
    directed("zero", 1'b1, 13'd500, 57'd0, 1'b0, 1'b0, 2'b00, 64'h8000_0000_0000_0000, 3'b000, 0);
    directed("nan", 1'b1, 13'd7, 57'd5, 1'b1, 1'b1, 2'b00, 64'h7FF8_0000_0000_0000, 3'b000, 0);
    directed("inf", 1'b1, 13'd7, 57'd5, 1'b0, 1'b1, 2'b01, 64'hFFF0_0000_0000_0000, 3'b000, 0);
    directed("stall", 1'b0, 13'd1023, 57'd3 << 55, 1'b0, 1'b0, 2'b00, 64'h4008_0000_0000_0000, 3'b000, 5);

    // reset during NORM aborts the operation
    send(1'b0, 13'd1033, 57'd1 << 45, 1'b0, 1'b0, 2'b00);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    chk("abort_valid", 64'(o_valid), 64'd0);
    chk("abort_ready", 64'(o_ready), 64'd1);
    chk("abort_result", o_result, 64'd0);
    chk("abort_flags", 64'(o_flags), 64'd0);
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    @(negedge i_clk);
    i_rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_valid) seen = 1'b1;
    end
    chk("abort_no_output", 64'(seen), 64'd0);

    // randomized operands
    for (int n = 0; n < 300; n++) begin
      m  = $urandom_range(0, 56);
      sg = 57'({$urandom(), $urandom()});
      sg = sg & ((57'd1 << (m + 1)) - 57'd1);
      sg[m] = 1'b1;
      if ($urandom_range(0, 3) == 0) sg[2:0] = 3'b100;
      if ($urandom_range(0, 15) == 0) sg = 57'd0;
      cat = $urandom_range(0, 4);
      case (cat)
        0: ev = $urandom_range(963, 1083);
        1: ev = $urandom_range(0, 130) - 70;
        2: ev = $urandom_range(1990, 2100);
        3: ev = $urandom_range(0, 8191) - 4096;
        default: ev = $urandom_range(1, 3);
      endcase
      ex = 13'(ev);
      hold = $urandom_range(0, 2);
      send(1'($urandom()), ex, sg, ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 19) == 0), 2'($urandom()));
      collect(hold, r, f);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
